cfg_frame_writer: RTL and testbench

Configuration-bus initiator that drives the enable/address/data_in memory-bank write port of a logic tile such as grid_clb. It accepts a byte-stream bitstream (valid/ready), parses a header carrying the start address and bit count, and issues one write strobe per configuration bit. Addresses auto-increment from the start address. It sits between the bitstream source (SPI/JTAG deserializer) and the tile config port.

---
 rtl/cfg_frame_writer.sv | 251 +++++++++++++++++++++++++
 tb/tb_cfg_frame_writer.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cfg_frame_writer.sv
`default_nettype none
// ============================================================================
// Module   : cfg_frame_writer
// Purpose  : Parses a byte-stream config frame (sync, address, count, data)
//            and drives one enable/address/data_in write per config bit.
//            Optional trailing XOR checksum: define CFG_FRAME_CRC_EN.
// Revision : 1.0 - initial release
// ============================================================================
module cfg_frame_writer #(
    parameter int ADDR_WIDTH    = 10,
    parameter int ENABLE_CYCLES = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [7:0]            s_data,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic                  abort,
    output logic                  enable,
    output logic [0:ADDR_WIDTH-1] address,
    output logic                  data_in,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);

    localparam int              c_ecw        = (ENABLE_CYCLES > 1) ? $clog2(ENABLE_CYCLES) : 1;
    localparam logic [c_ecw-1:0] c_en_last   = c_ecw'(ENABLE_CYCLES - 1);
    localparam logic [7:0]      c_sync_byte  = 8'hA5;
    localparam logic [16:0]     c_addr_limit = 17'd1 << ADDR_WIDTH;

`ifdef CFG_FRAME_CRC_EN
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_HDR    = 3'd1,
        S_LOAD   = 3'd2,
        S_SETUP  = 3'd3,
        S_STROBE = 3'd4,
        S_HOLD   = 3'd5,
        S_DONE   = 3'd6,
        S_CHECK  = 3'd7
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_HDR    = 3'd1,
        S_LOAD   = 3'd2,
        S_SETUP  = 3'd3,
        S_STROBE = 3'd4,
        S_HOLD   = 3'd5,
        S_DONE   = 3'd6
    } state_t;
`endif

    state_t                  state_q, state_d;
    state_t                  w_tail_state;
    logic [1:0]              hdr_cnt_q, hdr_cnt_d;
    logic [15:0]             start_q, start_d;
    logic [7:0]              cnt_hi_q, cnt_hi_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [15:0]             remain_q, remain_d;
    logic [7:0]              shift_q, shift_d;
    logic [2:0]              bit_q, bit_d;
    logic [c_ecw-1:0]        en_cnt_q, en_cnt_d;
    logic                    error_q, error_d;
    logic                    enable_q, enable_d;
    logic                    ready_q, ready_d;
`ifdef CFG_FRAME_CRC_EN
    logic [7:0]              xor_q, xor_d;
`endif

    logic                    w_accept;
    logic [15:0]             w_count;
    logic [16:0]             w_end;
    logic                    w_range_bad;

    assign w_accept    = s_valid && ready_q;
    assign w_count     = {cnt_hi_q, s_data};
    assign w_end       = {1'b0, start_q} + {1'b0, w_count};
    // 17-bit sum so a frame ending exactly at the top of the address space is legal
    assign w_range_bad = ((start_q >> ADDR_WIDTH) != 16'd0) || (w_end > c_addr_limit);

`ifdef CFG_FRAME_CRC_EN
    assign w_tail_state = S_CHECK;
`else
    assign w_tail_state = S_DONE;
`endif

    always_comb begin
        state_d   = state_q;
        hdr_cnt_d = hdr_cnt_q;
        start_d   = start_q;
        cnt_hi_d  = cnt_hi_q;
        addr_d    = addr_q;
        remain_d  = remain_q;
        shift_d   = shift_q;
        bit_d     = bit_q;
        en_cnt_d  = en_cnt_q;
        error_d   = error_q;
`ifdef CFG_FRAME_CRC_EN
        xor_d     = xor_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (w_accept && (s_data == c_sync_byte)) begin
                    error_d   = 1'b0;
                    hdr_cnt_d = 2'd0;
                    state_d   = S_HDR;
`ifdef CFG_FRAME_CRC_EN
                    xor_d     = 8'h00;
`endif
                end
            end
            S_HDR: begin
                if (w_accept) begin
                    hdr_cnt_d = hdr_cnt_q + 2'd1;
                    case (hdr_cnt_q)
                        2'd0:    start_d[15:8] = s_data;
                        2'd1:    start_d[7:0]  = s_data;
                        2'd2:    cnt_hi_d      = s_data;
                        default: begin
                            if (w_range_bad) begin
                                error_d = 1'b1;
                                state_d = S_IDLE;
                            end else if (w_count == 16'd0) begin
                                state_d = w_tail_state;
                            end else begin
                                addr_d   = start_q[ADDR_WIDTH-1:0];
                                remain_d = w_count;
                                state_d  = S_LOAD;
                            end
                        end
                    endcase
                end
            end
            S_LOAD: begin
                if (w_accept) begin
                    shift_d = s_data;
                    bit_d   = 3'd0;
                    state_d = S_SETUP;
`ifdef CFG_FRAME_CRC_EN
                    xor_d   = xor_q ^ s_data;
`endif
                end
            end
            S_SETUP: begin
                en_cnt_d = '0;
                state_d  = S_STROBE;
            end
            S_STROBE: begin
                if (en_cnt_q == c_en_last) begin
                    state_d = S_HOLD;
                end else begin
                    en_cnt_d = en_cnt_q + c_ecw'(1);
                end
            end
            S_HOLD: begin
                addr_d   = addr_q + ADDR_WIDTH'(1);
                remain_d = remain_q - 16'd1;
                bit_d    = bit_q + 3'd1;
                if (remain_q == 16'd1) begin
                    state_d = w_tail_state;
                end else if (bit_q == 3'd7) begin
                    state_d = S_LOAD;
                end else begin
                    state_d = S_SETUP;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
`ifdef CFG_FRAME_CRC_EN
            S_CHECK: begin
                if (w_accept) begin
                    if (s_data == xor_q) begin
                        state_d = S_DONE;
                    end else begin
                        error_d = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end
`endif
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Abort freezes the tile-facing address/data; enable falls because IDLE is not STROBE
        if (abort && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
            error_d = 1'b1;
            addr_d  = addr_q;
            shift_d = shift_q;
            bit_d   = bit_q;
        end

        enable_d = (state_d == S_STROBE);
        ready_d  = (state_d == S_IDLE) || (state_d == S_HDR) || (state_d == S_LOAD);
`ifdef CFG_FRAME_CRC_EN
        ready_d  = ready_d || (state_d == S_CHECK);
`endif
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            hdr_cnt_q <= 2'd0;
            start_q   <= 16'd0;
            cnt_hi_q  <= 8'd0;
            addr_q    <= '0;
            remain_q  <= 16'd0;
            shift_q   <= 8'd0;
            bit_q     <= 3'd0;
            en_cnt_q  <= '0;
            error_q   <= 1'b0;
            enable_q  <= 1'b0;
            ready_q   <= 1'b0;
`ifdef CFG_FRAME_CRC_EN
            xor_q     <= 8'h00;
`endif
        end else begin
            state_q   <= state_d;
            hdr_cnt_q <= hdr_cnt_d;
            start_q   <= start_d;
            cnt_hi_q  <= cnt_hi_d;
            addr_q    <= addr_d;
            remain_q  <= remain_d;
            shift_q   <= shift_d;
            bit_q     <= bit_d;
            en_cnt_q  <= en_cnt_d;
            error_q   <= error_d;
            enable_q  <= enable_d;
            ready_q   <= ready_d;
`ifdef CFG_FRAME_CRC_EN
            xor_q     <= xor_d;
`endif
        end
    end

    assign s_ready = ready_q;
    assign enable  = enable_q;
    assign address = addr_q;
    assign data_in = shift_q[bit_q];
    assign busy    = (state_q != S_IDLE);
    assign done    = (state_q == S_DONE);
    assign error   = error_q;

endmodule
`default_nettype wire

// File: tb/tb_cfg_frame_writer.sv
`default_nettype none
// ============================================================================
// Module   : tb_cfg_frame_writer
// Purpose  : Randomized and directed frames for cfg_frame_writer, checked
//            against an address/bit list derived from the frame contents.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cfg_frame_writer;

    localparam int AW = 10;
    localparam int EC = 1;
`ifdef CFG_FRAME_CRC_EN
    localparam bit CRC_ON = 1'b1;
`else
    localparam bit CRC_ON = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [7:0]    s_data = 8'h00;
    logic          s_valid = 1'b0;
    logic          abort = 1'b0;
    logic          s_ready, enable, data_in, busy, done, error;
    logic [AW-1:0] address;

    cfg_frame_writer #(.ADDR_WIDTH(AW), .ENABLE_CYCLES(EC)) dut (
        .clk(clk), .reset_n(reset_n), .s_data(s_data), .s_valid(s_valid),
        .s_ready(s_ready), .abort(abort), .enable(enable), .address(address),
        .data_in(data_in), .busy(busy), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Expected tile writes, in order
    int exp_addr[$];
    bit exp_data[$];
    bit exp_same[$];

    int cyc = 0, strobe_cnt = 0, done_cnt = 0, last_rise = 0, hi_len = 0;
    logic prev_en = 1'b0, prev_d = 1'b0, prev_done = 1'b0;
    logic [AW-1:0] prev_a = '0;
    int m_a;
    bit m_d, m_s;

    always @(posedge clk) begin
        #1;
        cyc++;
        if (reset_n) begin
            if (enable) begin
                check("strobe_addr_stable", address, prev_a);
                check("strobe_data_stable", data_in, prev_d);
                check("ready_low_in_strobe", s_ready, 0);
            end else if (prev_en) begin
                check("hold_addr_stable", address, prev_a);
                check("hold_data_stable", data_in, prev_d);
                check("strobe_width", hi_len, EC);
            end
            if (enable && !prev_en) begin
                strobe_cnt++;
                check("strobe_expected", exp_addr.size() > 0, 1);
                if (exp_addr.size() > 0) begin
                    m_a = exp_addr.pop_front();
                    m_d = exp_data.pop_front();
                    m_s = exp_same.pop_front();
                    check("write_addr", address, m_a);
                    check("write_data", data_in, m_d);
                    if (m_s) check("bit_spacing", cyc - last_rise, EC + 2);
                end
                last_rise = cyc;
                hi_len = 0;
            end
            if (enable) hi_len++;
            if (done) begin
                done_cnt++;
                check("done_single_cycle", prev_done, 0);
            end
        end
        prev_en = enable;
        prev_a = address;
        prev_d = data_in;
        prev_done = done;
    end

    task automatic send_byte(input logic [7:0] b, input int stall);
        int n;
        logic acc;
        repeat (stall) @(negedge clk);
        s_data = b;
        s_valid = 1'b1;
        n = 0;
        forever begin
            acc = s_ready;
            @(negedge clk);
            if (acc) break;
            n++;
            if (n > 5000) begin
                check("accept_timeout", n, 0);
                break;
            end
        end
        s_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("idle_within_budget", n < 3000, 1);
    endtask

    logic [7:0] fix_q[$];

    // Model: a legal frame writes bit i of the payload to start+i, LSB first
    task automatic run_frame(input int start, input int n, input int stall_max,
                             input int data_stall, input bit crc_bad);
        logic [7:0] data[$];
        logic [7:0] x;
        int nbytes, d0;
        bit legal, exp_done, exp_err;
        legal = (start < (1 << AW)) && ((start + n) <= (1 << AW));
        nbytes = (n + 7) / 8;
        x = 8'h00;
        for (int i = 0; i < nbytes; i++) begin
            if (fix_q.size() > 0) data.push_back(fix_q.pop_front());
            else data.push_back(8'($urandom));
            x ^= data[i];
        end
        fix_q.delete();
        if (legal) begin
            for (int i = 0; i < n; i++) begin
                exp_addr.push_back(start + i);
                exp_data.push_back(data[i / 8][i % 8]);
                exp_same.push_back((i % 8) != 0);
            end
        end
        exp_done = legal && !(CRC_ON && crc_bad);
        exp_err  = !legal || (CRC_ON && crc_bad);
        d0 = done_cnt;
        send_byte(8'hA5, $urandom_range(0, stall_max));
        send_byte(8'(start >> 8), $urandom_range(0, stall_max));
        send_byte(8'(start), $urandom_range(0, stall_max));
        send_byte(8'(n >> 8), $urandom_range(0, stall_max));
        send_byte(8'(n), $urandom_range(0, stall_max));
        if (legal) begin
            for (int i = 0; i < nbytes; i++)
                send_byte(data[i], (i > 0) ? data_stall : $urandom_range(0, stall_max));
            if (CRC_ON) send_byte(x ^ {7'd0, crc_bad}, $urandom_range(0, stall_max));
        end
        wait_idle();
        repeat (2) @(negedge clk);
        check("frame_done_count", done_cnt - d0, exp_done);
        check("frame_error", error, exp_err);
        check("frame_all_writes_seen", exp_addr.size(), 0);
        check("frame_busy_low", busy, 0);
    endtask

    initial begin : g_watchdog
        #3000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n, s0, st;
        logic [7:0] d;

        repeat (3) @(negedge clk);
        check("rst_enable", enable, 0);
        check("rst_address", address, 0);
        check("rst_data_in", data_in, 0);
        check("rst_s_ready", s_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_error", error, 0);
        reset_n = 1'b1;
        @(negedge clk);
        check("idle_s_ready", s_ready, 1);

        // Range failure: 0x3FF + 2 exceeds 1024
        run_frame(16'h03FF, 2, 0, 0, 1'b0);
        send_byte(8'h00, 0);
        send_byte(8'h12, 0);
        check("error_sticky_in_idle", error, 1);
        check("range_busy", busy, 0);

        // Start 16, N=3, data 0x05
        fix_q.push_back(8'h05);
        run_frame(16, 3, 0, 0, 1'b0);

        // Non-sync bytes discarded, then an empty frame
        send_byte(8'h12, 0);
        send_byte(8'h34, 0);
        run_frame(0, 0, 0, 0, 1'b0);

        // N=12 from 0, FF 0F, 5-cycle source stall between data bytes
        fix_q.push_back(8'hFF);
        fix_q.push_back(8'h0F);
        run_frame(0, 12, 0, 5, 1'b0);

        // Frame reaching exactly the top address, and high address bits set
        run_frame((1 << AW) - 9, 9, 1, 0, 1'b0);
        run_frame(16'h0400, 1, 0, 0, 1'b0);

`ifdef CFG_FRAME_CRC_EN
        fix_q.push_back(8'hAA);
        fix_q.push_back(8'h55);
        run_frame(0, 16, 0, 0, 1'b1);
        fix_q.push_back(8'hAA);
        fix_q.push_back(8'h55);
        run_frame(0, 16, 0, 0, 1'b0);
`endif

        for (int k = 0; k < 24; k++) begin
            st = $urandom_range(0, 4);
            n = $urandom_range(0, 40);
            if (st == 0) begin
                if (n == 0) n = 1;
                run_frame($urandom_range((1 << AW) - n + 1, 16'hFFFF), n, 2, 0, 1'b0);
            end else begin
                run_frame($urandom_range(0, (1 << AW) - n), n, 3, $urandom_range(0, 3),
                          CRC_ON && (st == 1));
            end
        end

        // Abort during the third strobe of an 8-bit frame at 100
        d = 8'($urandom);
        for (int i = 0; i < 3; i++) begin
            exp_addr.push_back(100 + i);
            exp_data.push_back(d[i]);
            exp_same.push_back(i != 0);
        end
        s0 = strobe_cnt;
        send_byte(8'hA5, 0);
        send_byte(8'h00, 0);
        send_byte(8'd100, 0);
        send_byte(8'h00, 0);
        send_byte(8'h08, 0);
        send_byte(d, 0);
        n = 0;
        while (!(enable && strobe_cnt == s0 + 3) && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("abort_third_strobe_reached", n < 500, 1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_enable_low", enable, 0);
        check("abort_error", error, 1);
        check("abort_busy", busy, 0);
        check("abort_addr_held", address, 102);
        check("abort_data_held", data_in, d[2]);
        repeat (6) @(negedge clk);
        check("abort_strobe_total", strobe_cnt - s0, 3);
        check("abort_writes_seen", exp_addr.size(), 0);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_idle_noeffect_busy", busy, 0);

        // A valid frame after the abort clears error
        run_frame(300, 5, 1, 0, 1'b0);

        // Asynchronous reset in the middle of a strobe
        for (int i = 0; i < 8; i++) begin
            exp_addr.push_back(200 + i);
            exp_data.push_back(1'b1);
            exp_same.push_back(i != 0);
        end
        send_byte(8'hA5, 0);
        send_byte(8'h00, 0);
        send_byte(8'd200, 0);
        send_byte(8'h00, 0);
        send_byte(8'h08, 0);
        send_byte(8'hFF, 0);
        n = 0;
        while (!enable && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("reset_strobe_reached", enable, 1);
        #2 reset_n = 1'b0;
        #1;
        check("async_rst_enable", enable, 0);
        check("async_rst_busy", busy, 0);
        check("async_rst_address", address, 0);
        exp_addr.delete();
        exp_data.delete();
        exp_same.delete();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        run_frame(512, 10, 1, 1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
